// File: rtl/mod_n_updn_counter.sv
// Mod-N up/down counter digit with carry/borrow chaining and a button-driven set mode.
// Define MODN_CNT_AUTOREPEAT_EN to add hold-to-repeat stepping on the adjust buttons.
module mod_n_updn_counter #(
    parameter int unsigned MODULUS      = 10,
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic             dir,
    input  logic             adj_mode,
    input  logic             btn_up,
    input  logic             btn_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             carry_p,
    output logic             carry_m,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    // Elaboration-time parameter range guards
    if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("mod_n_updn_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (REPEAT_DELAY < 2 || REPEAT_DELAY > 65535) begin : g_bad_delay
        $error("mod_n_updn_counter: REPEAT_DELAY must be in 2..65535");
    end
    if (REPEAT_RATE < 1 || REPEAT_RATE > 65535) begin : g_bad_rate
        $error("mod_n_updn_counter: REPEAT_RATE must be in 1..65535");
    end

    logic             btn_up_q;
    logic             btn_dn_q;
    logic             edge_arm;
    logic             up_rise;
    logic             dn_rise;
    logic             up_edge;
    logic             dn_edge;
    logic             adj_up;
    logic             adj_dn;
    logic             at_zero;
    logic             load_ok;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;
    logic [WIDTH-1:0] count_d;
    logic             carry_p_d;
    logic             carry_m_d;

    // Level history for edge detection; edge_arm masks the first cycle after reset
    // so a button held through reset cannot look like a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_up_q <= 1'b0;
            btn_dn_q <= 1'b0;
            edge_arm <= 1'b0;
        end else begin
            btn_up_q <= btn_up;
            btn_dn_q <= btn_dn;
            edge_arm <= 1'b1;
        end
    end

    assign up_rise = btn_up & ~btn_up_q & edge_arm;
    assign dn_rise = btn_dn & ~btn_dn_q & edge_arm;
    // An edge only counts while the other button is released
    assign up_edge = adj_mode & up_rise & ~btn_dn;
    assign dn_edge = adj_mode & dn_rise & ~btn_up;

`ifdef MODN_CNT_AUTOREPEAT_EN
    localparam int unsigned        TIMER_W = 16;
    localparam logic [TIMER_W-1:0] DELAY_T = TIMER_W'(REPEAT_DELAY);
    localparam logic [TIMER_W-1:0] RATE_T  = TIMER_W'(REPEAT_RATE);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_HOLD,
        RPT_REPEAT
    } rpt_state_t;

    rpt_state_t         rpt_state;
    logic [TIMER_W-1:0] rpt_timer;
    logic               rpt_dn;
    logic               held_ok;
    logic               rpt_step;

    assign held_ok  = adj_mode & ~load &
                      (rpt_dn ? (btn_dn & ~btn_up) : (btn_up & ~btn_dn));
    assign rpt_step = held_ok &
                      (((rpt_state == RPT_HOLD)   && (rpt_timer == DELAY_T)) ||
                       ((rpt_state == RPT_REPEAT) && (rpt_timer == RATE_T)));

    // Timer holds the number of cycles since the last step while a single button stays down
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_state <= RPT_IDLE;
            rpt_timer <= '0;
            rpt_dn    <= 1'b0;
        end else begin
            case (rpt_state)
                RPT_IDLE: begin
                    rpt_timer <= '0;
                    if (!load && (up_edge || dn_edge)) begin
                        rpt_state <= RPT_HOLD;
                        rpt_timer <= TIMER_W'(1);
                        rpt_dn    <= dn_edge;
                    end
                end
                RPT_HOLD: begin
                    if (!held_ok) begin
                        rpt_state <= RPT_IDLE;
                        rpt_timer <= '0;
                    end else if (rpt_timer == DELAY_T) begin
                        rpt_state <= RPT_REPEAT;
                        rpt_timer <= TIMER_W'(1);
                    end else begin
                        rpt_timer <= rpt_timer + TIMER_W'(1);
                    end
                end
                RPT_REPEAT: begin
                    if (!held_ok) begin
                        rpt_state <= RPT_IDLE;
                        rpt_timer <= '0;
                    end else if (rpt_timer == RATE_T) begin
                        rpt_timer <= TIMER_W'(1);
                    end else begin
                        rpt_timer <= rpt_timer + TIMER_W'(1);
                    end
                end
                default: begin
                    rpt_state <= RPT_IDLE;
                    rpt_timer <= '0;
                end
            endcase
        end
    end

    assign adj_up = up_edge | (rpt_step & ~rpt_dn);
    assign adj_dn = dn_edge | (rpt_step &  rpt_dn);
`else
    assign adj_up = up_edge;
    assign adj_dn = dn_edge;
`endif

    assign at_max    = (count == CNT_MAX);
    assign at_zero   = (count == '0);
    assign count_inc = at_max  ? '0      : count + WIDTH'(1);
    assign count_dec = at_zero ? CNT_MAX : count - WIDTH'(1);
    assign load_ok   = ({1'b0, load_val} < MOD_EXT);

    // Next value: load, then adjust step (never carries), then chained count step
    always_comb begin
        count_d   = count;
        carry_p_d = 1'b0;
        carry_m_d = 1'b0;
        if (load) begin
            count_d = load_ok ? load_val : '0;
        end else if (adj_mode) begin
            if (adj_up) begin
                count_d = count_inc;
            end else if (adj_dn) begin
                count_d = count_dec;
            end
        end else if (cnt_en) begin
            if (!dir) begin
                count_d   = count_inc;
                carry_p_d = at_max;
            end else begin
                count_d   = count_dec;
                carry_m_d = at_zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            carry_p <= 1'b0;
            carry_m <= 1'b0;
        end else begin
            count   <= count_d;
            carry_p <= carry_p_d;
            carry_m <= carry_m_d;
        end
    end

endmodule

// File: tb/tb_mod_n_updn_counter.sv
// Scoreboard bench for mod_n_updn_counter: a MODULUS=10 digit and a MODULUS=6 digit.
module tb_mod_n_updn_counter;

    localparam int unsigned W = 4;
`ifdef MODN_CNT_AUTOREPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         cnt_en   = 1'b0;
    logic         dir      = 1'b0;
    logic         adj_mode = 1'b0;
    logic         btn_up   = 1'b0;
    logic         btn_dn   = 1'b0;
    logic         load     = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         cnt_en6  = 1'b0;
    logic         load6    = 1'b0;
    logic         tie0     = 1'b0;
    logic [W-1:0] count;
    logic [W-1:0] count6;
    logic         carry_p;
    logic         carry_m;
    logic         at_max;
    logic         carry_p6;
    logic         carry_m6;
    logic         at_max6;

    always #5 clk = ~clk;

    mod_n_updn_counter #(.MODULUS(10), .WIDTH(W), .REPEAT_DELAY(8), .REPEAT_RATE(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .cnt_en   (cnt_en),
        .dir      (dir),
        .adj_mode (adj_mode),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .carry_p  (carry_p),
        .carry_m  (carry_m),
        .at_max   (at_max)
    );

    mod_n_updn_counter #(.MODULUS(6), .WIDTH(W), .REPEAT_DELAY(8), .REPEAT_RATE(4)) u_dut6 (
        .clk      (clk),
        .rst      (rst),
        .cnt_en   (cnt_en6),
        .dir      (dir),
        .adj_mode (tie0),
        .btn_up   (tie0),
        .btn_dn   (tie0),
        .load     (load6),
        .load_val (load_val),
        .count    (count6),
        .carry_p  (carry_p6),
        .carry_m  (carry_m6),
        .at_max   (at_max6)
    );

    typedef struct {
        string        nm;
        logic [W-1:0] cnt;
        logic         cp;
        logic         cm;
        logic         s6;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, req);
    endtask

    // Drive one cycle of stimulus and queue the state expected after the next edge
    task automatic vec(input string nm, input int r, input int c, input int d, input int a,
                       input int u, input int n, input int l, input int lv,
                       input int ec, input int ecp, input int ecm, input int s6);
        exp_t e;
        @(negedge clk);
        rst      = (r != 0);
        dir      = (d != 0);
        adj_mode = (a != 0);
        btn_up   = (u != 0);
        btn_dn   = (n != 0);
        cnt_en   = (c != 0) && (s6 == 0);
        cnt_en6  = (c != 0) && (s6 != 0);
        load     = (l != 0) && (s6 == 0);
        load6    = (l != 0) && (s6 != 0);
        load_val = W'(lv);
        e.nm  = nm;
        e.cnt = W'(ec);
        e.cp  = (ecp != 0);
        e.cm  = (ecm != 0);
        e.s6  = (s6 != 0);
        sbq.push_back(e);
    endtask

    // Steps at hold cycles 0, 8, 12, 16 with repeat; only the first edge without it
    function automatic int rep_cnt(input int k);
        if (RPT_EN) return 1 + int'(k >= 8) + int'(k >= 12) + int'(k >= 16);
        return 1;
    endfunction

    // Monitor: one scoreboard entry per clock, sampled just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                if (e.s6) begin
                    chk({e.nm, "_count"},  int'(count6),   int'(e.cnt));
                    chk({e.nm, "_carryp"}, int'(carry_p6), int'(e.cp));
                    chk({e.nm, "_carrym"}, int'(carry_m6), int'(e.cm));
                    chk({e.nm, "_atmax"},  int'(at_max6),  int'(e.cnt == 4'd5));
                end else begin
                    chk({e.nm, "_count"},  int'(count),    int'(e.cnt));
                    chk({e.nm, "_carryp"}, int'(carry_p),  int'(e.cp));
                    chk({e.nm, "_carrym"}, int'(carry_m),  int'(e.cm));
                    chk({e.nm, "_atmax"},  int'(at_max),   int'(e.cnt == 4'd9));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //   name           r c d a u n l lv  cnt cp cm s6
        vec("reset",        1,0,0,0,0,0,0, 0,  0, 0,0, 0);
        vec("rst_prio",     1,1,0,0,0,0,1, 5,  0, 0,0, 0);
        vec("load9",        0,0,0,0,0,0,1, 9,  9, 0,0, 0);
        vec("wrap_up",      0,1,0,0,0,0,0, 0,  0, 1,0, 0);
        vec("cp_clear",     0,0,0,0,0,0,0, 0,  0, 0,0, 0);
        vec("inc",          0,1,0,0,0,0,0, 0,  1, 0,0, 0);
        vec("dec",          0,1,1,0,0,0,0, 0,  0, 0,0, 0);
        vec("wrap_dn",      0,1,1,0,0,0,0, 0,  9, 0,1, 0);
        vec("cm_clear",     0,0,1,0,0,0,0, 0,  9, 0,0, 0);
        vec("load_oor",     0,0,0,0,0,0,1,12,  0, 0,0, 0);
        vec("load_prio",    0,1,0,0,0,0,1, 7,  7, 0,0, 0);
        vec("load9b",       0,0,0,0,0,0,1, 9,  9, 0,0, 0);
        vec("load_nocarry", 0,1,0,0,0,0,1, 3,  3, 0,0, 0);
        vec("load9c",       0,0,0,0,0,0,1, 9,  9, 0,0, 0);
        vec("adj_ign_en",   0,1,0,1,0,0,0, 0,  9, 0,0, 0);
        vec("adj_wrap_up",  0,1,0,1,1,0,0, 0,  0, 0,0, 0);
        vec("adj_hold",     0,0,0,1,1,0,0, 0,  0, 0,0, 0);
        vec("adj_rel",      0,0,0,1,0,0,0, 0,  0, 0,0, 0);
        vec("adj_both",     0,0,0,1,1,1,0, 0,  0, 0,0, 0);
        vec("adj_both_held",0,0,0,1,1,1,0, 0,  0, 0,0, 0);
        vec("adj_both_rel", 0,0,0,1,0,0,0, 0,  0, 0,0, 0);
        vec("adj_wrap_dn",  0,1,1,1,0,1,0, 0,  9, 0,0, 0);
        vec("adj_up_on_dn", 0,0,0,1,1,1,0, 0,  9, 0,0, 0);
        vec("adj_rel2",     0,0,0,1,0,0,0, 0,  9, 0,0, 0);
        vec("edge_discard", 0,0,0,0,1,0,0, 0,  9, 0,0, 0);
        vec("mode_rise",    0,0,0,1,1,0,0, 0,  9, 0,0, 0);
        vec("mode_rel",     0,0,0,1,0,0,0, 0,  9, 0,0, 0);
        vec("dn_step",      0,0,0,1,0,1,0, 0,  8, 0,0, 0);
        vec("dn_rel",       0,0,0,1,0,0,0, 0,  8, 0,0, 0);
        vec("adj_load",     0,0,0,1,0,0,1, 0,  0, 0,0, 0);
        for (int k = 0; k < 20; k++)
            vec($sformatf("rep_k%0d", k), 0,0,0,1,1,0,0, 0, rep_cnt(k), 0,0, 0);
        vec("rep_rel",      0,0,0,1,0,0,0, 0, rep_cnt(19), 0,0, 0);
        vec("pre_rst_load", 0,0,0,1,0,0,1, 0,  0, 0,0, 0);
        for (int k = 0; k < 14; k++)
            vec($sformatf("hold_k%0d", k), 0,0,0,1,1,0,0, 0, rep_cnt(k), 0,0, 0);
        vec("rst_mid_rep",  1,0,0,1,1,0,0, 0,  0, 0,0, 0);
        for (int k = 0; k < 12; k++)
            vec($sformatf("post_rst_k%0d", k), 0,0,0,1,1,0,0, 0, 0, 0,0, 0);
        vec("post_rst_rel", 0,0,0,1,0,0,0, 0,  0, 0,0, 0);
        vec("new_edge",     0,0,0,1,1,0,0, 0,  1, 0,0, 0);
        vec("new_edge_rel", 0,0,0,1,0,0,0, 0,  1, 0,0, 0);
        vec("m6_wrap_dn",   0,1,1,0,0,0,0, 0,  5, 0,1, 1);
        vec("m6_cm_clear",  0,0,1,0,0,0,0, 0,  5, 0,0, 1);
        vec("m6_wrap_up",   0,1,0,0,0,0,0, 0,  0, 1,0, 1);
        vec("m6_load_oor",  0,0,0,0,0,0,1, 7,  0, 0,0, 1);
        vec("m6_load5",     0,0,0,0,0,0,1, 5,  5, 0,0, 1);
        vec("m6_idle",      0,0,0,0,0,0,0, 0,  5, 0,0, 1);

        @(negedge clk);
        cnt_en  = 1'b0;
        cnt_en6 = 1'b0;
        load    = 1'b0;
        load6   = 1'b0;
        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
        chk("drain", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mod_n_updn_counter.md
MOD_N_UPDN_COUNTER -- requirements
Module: mod_n_updn_counter

Interface
REQ-001 SHALL have parameter MODULUS, default 10, count range 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-002 SHALL have parameter WIDTH, default 4, bit width of count and load_val.
REQ-003 SHALL have parameter REPEAT_DELAY, default 500, hold cycles before auto-repeat starts (range 2..65535).
REQ-004 SHALL have parameter REPEAT_RATE, default 100, cycles between auto-repeat steps (range 1..65535).
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port cnt_en, input, 1, one-cycle count strobe from the prescaler or from a lower digit's carry/borrow.
REQ-008 SHALL have port dir, input, 1, count direction: 0 = up, 1 = down.
REQ-009 SHALL have port adj_mode, input, 1, set mode: 1 = buttons adjust the count and cnt_en is ignored.
REQ-010 SHALL have port btn_up, input, 1, active-high, already synchronised and debounced, increment request.
REQ-011 SHALL have port btn_dn, input, 1, active-high, already synchronised and debounced, decrement request.
REQ-012 SHALL have port load, input, 1, parallel load strobe.
REQ-013 SHALL have port load_val, input, WIDTH, value to load.
REQ-014 SHALL have port count, output, WIDTH, registered current value.
REQ-015 SHALL have port carry_p, output, 1, registered one-cycle pulse on up-wrap.
REQ-016 SHALL have port carry_m, output, 1, registered one-cycle pulse on down-wrap (borrow).
REQ-017 SHALL have port at_max, output, 1, combinational flag, high when count == MODULUS-1.

Function
REQ-018 Per-edge priority SHALL be: rst > load > adjust step > cnt_en step.
REQ-019 load SHALL set count to load_val when load_val < MODULUS, and to 0 otherwise; carry_p and carry_m SHALL be 0 in that cycle.
REQ-020 On a cnt_en step with dir=0, count SHALL become count+1, or 0 when count == MODULUS-1, with carry_p=1 for exactly the following cycle.
REQ-021 On a cnt_en step with dir=1, count SHALL become count-1, or MODULUS-1 when count == 0, with carry_m=1 for exactly the following cycle.
REQ-022 Count/carry latency SHALL be 1 clock from the sampled strobe; carry_p/carry_m SHALL be 0 in every cycle without a wrap step.
REQ-023 With adj_mode=1, cnt_en SHALL be ignored.
REQ-024 With adj_mode=1, a rising edge of btn_up (registered previous-level compare) SHALL step count up with wrap, and a rising edge of btn_dn SHALL step count down with wrap.
REQ-025 Adjust-mode wraps SHALL NOT assert carry_p or carry_m, so that adjusting one digit does not disturb the next digit.
REQ-026 Simultaneous btn_up and btn_dn rising edges SHALL cause no step; while both buttons are held, no step SHALL occur.
REQ-027 Button edges occurring while adj_mode=0 SHALL be discarded, not queued; the edge detector SHALL track levels regardless of mode.
REQ-028 A 0->1 transition of adj_mode while a button is held SHALL NOT produce a step.

Reset
REQ-029 rst=1 SHALL set count=0, carry_p=0, carry_m=0, clear the button-edge registers to 0, and put the repeat FSM in IDLE with its timer at 0.
REQ-030 rst SHALL take effect at the next clk edge regardless of any other input, including mid-repeat.
REQ-031 After rst is released, no spurious step SHALL occur from buttons already held during reset.

Configuration
REQ-032 Macro MODN_CNT_AUTOREPEAT_EN SHALL compile in the auto-repeat FSM and timer.
REQ-033 With MODN_CNT_AUTOREPEAT_EN defined, the FSM SHALL have three states:
- IDLE -> HOLD on an accepted adjust edge.
- HOLD -> REPEAT after REPEAT_DELAY cycles of the same single button held.
- In REPEAT, one step (no carry) every REPEAT_RATE cycles.
- Any state -> IDLE on button release, both buttons held, adj_mode=0, or load.
REQ-034 Without MODN_CNT_AUTOREPEAT_EN, only single edge-triggered steps SHALL occur, and no timer logic SHALL exist.

Verification
REQ-035 MODULUS=10, count=9, dir=0, cnt_en pulse -> count=0 and carry_p=1 for one cycle.
REQ-036 MODULUS=6, count=0, dir=1, cnt_en pulse -> count=5 and carry_m=1 for one cycle.
REQ-037 adj_mode=1, count=9, btn_up rising edge -> count=0 and carry_p stays 0; btn_up and btn_dn rising in the same cycle -> count unchanged.
REQ-038 load_val=12 with MODULUS=10 -> count=0; load and cnt_en in the same cycle with load_val=7 -> count=7.
REQ-039 With the macro defined, REPEAT_DELAY=8 and REPEAT_RATE=4, btn_up held 20 cycles from count=0 -> steps at hold cycles 0, 8, 12, 16, giving count=4.
REQ-040 rst asserted mid-REPEAT with btn_up still held -> count=0 next cycle, and no steps occur after rst is released until a new rising edge.
